// File: rtl/fft_input_loader.sv
// fft_input_loader: ping-pong frame buffer that sits between an audio sample
// stream and an FFT engine. Real samples are sign-extended into complex words
// {re, im=0} and stored at bit-reversed addresses, so the FFT can read each
// frame in natural order as the input of an in-place decimation-in-time pass.
//
// Optional feature: define FFT_LOADER_DROP_CNT_EN to add o_drop_cnt, a
// saturating 16-bit count of samples dropped because both banks were full.
//
// Handshake: there is no back-pressure. i_sample_valid means "take this sample
// now"; if the bank being written is still full it is dropped and o_overflow
// sticks high. i_rd_en is a plain one-cycle-latency read strobe. i_frame_done
// is a single-cycle release of the bank being read, honoured only while
// o_frame_ready is high.
module fft_input_loader #(
  parameter int DATA_WIDTH   = 24,
  parameter int SAMPLE_WIDTH = 24,
  parameter int FFT_POINTS   = 1024,
  localparam int ADDR_W      = $clog2(FFT_POINTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]   i_sample,
  input  logic                      i_rd_en,
  input  logic [ADDR_W-1:0]         i_rd_addr,
  input  logic                      i_frame_done,
  output logic [2*DATA_WIDTH-1:0]   o_rd_data,
  output logic                      o_frame_ready,
`ifdef FFT_LOADER_DROP_CNT_EN
  output logic [15:0]               o_drop_cnt,
`endif
  output logic                      o_overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FFT_POINTS - 1);

  // Both banks live in one array; the bank index is the top address bit.
  logic [2*DATA_WIDTH-1:0] mem [0:2*FFT_POINTS-1];

  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wr_cnt;
  logic [1:0]        full;

  logic              wr_fire;
  logic              drop;
  logic              release_rd;
  logic              frame_last;
  logic [1:0]        full_n;
  logic [ADDR_W-1:0] wr_addr;
  logic signed [DATA_WIDTH-1:0] sample_ext;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

  assign sample_ext = DATA_WIDTH'($signed(i_sample));
  assign wr_addr    = bitrev(wr_cnt);

  // Decode this cycle's write, drop and release events and the next full mask.
  // A completing write and a release never hit the same bank: writes need the
  // bank empty, releases need it full.
  always_comb begin
    wr_fire    = i_sample_valid && !full[wr_bank];
    drop       = i_sample_valid &&  full[wr_bank];
    release_rd = i_frame_done   &&  full[rd_bank];
    frame_last = wr_fire && (wr_cnt == LAST_ADDR);
    full_n     = full;
    if (frame_last) full_n[wr_bank] = 1'b1;
    if (release_rd) full_n[rd_bank] = 1'b0;
  end

  // Bank bookkeeping and status flags; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      full       <= 2'b00;
      o_overflow <= 1'b0;
    end else begin
      full <= full_n;
      if (wr_fire)    wr_cnt  <= wr_cnt + 1'b1;
      if (frame_last) wr_bank <= ~wr_bank;
      if (release_rd) rd_bank <= ~rd_bank;
      if (drop)       o_overflow <= 1'b1;
    end
  end

  // Sample storage; contents survive reset, and only an empty bank is written.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire)
      mem[{wr_bank, wr_addr}] <= {sample_ext, {DATA_WIDTH{1'b0}}};
  end

  // Registered read port: data appears one cycle after i_rd_en and then holds.
  always_ff @(posedge clk) begin
    if (reset)        o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= mem[{rd_bank, i_rd_addr}];
  end

  assign o_frame_ready = full[rd_bank];

`ifdef FFT_LOADER_DROP_CNT_EN
  // Saturating count of dropped samples.
  always_ff @(posedge clk) begin
    if (reset)                              o_drop_cnt <= 16'h0000;
    else if (drop && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader with FFT_POINTS=8, DATA_WIDTH=24,
// SAMPLE_WIDTH=16. Samples are addressed bit-reversed over 3 bits, so
// sample index k lands at address {k[0],k[1],k[2]}.
module tb_fft_input_loader;
  localparam int DW = 24;
  localparam int SW = 16;
  localparam int NP = 8;
  localparam int AW = 3;

  // clock/reset block
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_sample_valid = 1'b0;
  logic [SW-1:0] i_sample = '0;
  logic          i_rd_en = 1'b0;
  logic [AW-1:0] i_rd_addr = '0;
  logic          i_frame_done = 1'b0;
  logic [2*DW-1:0] o_rd_data;
  logic          o_frame_ready;
  logic          o_overflow;
`ifdef FFT_LOADER_DROP_CNT_EN
  logic [15:0]   o_drop_cnt;
`endif

  always #5 clk = ~clk;

  fft_input_loader #(.DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .FFT_POINTS(NP)) dut (
    .clk(clk),
    .reset(reset),
    .i_sample_valid(i_sample_valid),
    .i_sample(i_sample),
    .i_rd_en(i_rd_en),
    .i_rd_addr(i_rd_addr),
    .i_frame_done(i_frame_done),
    .o_rd_data(o_rd_data),
    .o_frame_ready(o_frame_ready),
`ifdef FFT_LOADER_DROP_CNT_EN
    .o_drop_cnt(o_drop_cnt),
`endif
    .o_overflow(o_overflow)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  function automatic logic [2*DW-1:0] cword(input logic [DW-1:0] re);
    return {re, {DW{1'b0}}};
  endfunction

  // driver tasks: inputs change 1 time unit after the rising edge, outputs
  // are sampled at that same point, well away from the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [SW-1:0] s, input logic done);
    i_sample_valid = 1'b1;
    i_sample       = s;
    i_frame_done   = done;
    tick();
    i_sample_valid = 1'b0;
    i_frame_done   = 1'b0;
  endtask

  task automatic send_range(input int base, input int n);
    for (int k = 0; k < n; k++) send(SW'(base + k), 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    i_rd_en   = 1'b1;
    i_rd_addr = a;
    tick();
    i_rd_en   = 1'b0;
  endtask

  task automatic frame_done();
    i_frame_done = 1'b1;
    tick();
    i_frame_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++; if (o_frame_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", o_frame_ready); else pass_cnt++;
    chk_cnt++; if (o_overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", o_overflow); else pass_cnt++;
    chk_cnt++; if (o_rd_data !== '0) $display("FAIL reset_rd_data got %h want 0", o_rd_data); else pass_cnt++;
`ifdef FFT_LOADER_DROP_CNT_EN
    chk_cnt++; if (o_drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt got %0d want 0", o_drop_cnt); else pass_cnt++;
`endif
    // release while nothing is ready must be ignored
    frame_done();
    chk_cnt++; if (o_frame_ready !== 1'b0) $display("FAIL idle_done_ready got %b want 0", o_frame_ready); else pass_cnt++;
  endtask

  task automatic test_first_frame();
    send_range(0, 7);
    chk_cnt++; if (o_frame_ready !== 1'b0) $display("FAIL ready_after_7 got %b want 0", o_frame_ready); else pass_cnt++;
    send(SW'(7), 1'b0);
    // ready after the 8th sample also shows the earlier idle release left rd_bank at 0
    chk_cnt++; if (o_frame_ready !== 1'b1) $display("FAIL ready_after_8 got %b want 1", o_frame_ready); else pass_cnt++;
    rd(3'd1);
    chk_cnt++; if (o_rd_data !== cword(24'd4)) $display("FAIL rd_addr1 got %h want %h", o_rd_data, cword(24'd4)); else pass_cnt++;
    rd(3'd6);
    chk_cnt++; if (o_rd_data !== cword(24'd3)) $display("FAIL rd_addr6 got %h want %h", o_rd_data, cword(24'd3)); else pass_cnt++;
    rd(3'd3);
    chk_cnt++; if (o_rd_data !== cword(24'd6)) $display("FAIL rd_addr3 got %h want %h", o_rd_data, cword(24'd6)); else pass_cnt++;
    tick();
    tick();
    chk_cnt++; if (o_rd_data !== cword(24'd6)) $display("FAIL rd_hold got %h want %h", o_rd_data, cword(24'd6)); else pass_cnt++;
  endtask

  task automatic test_overflow();
    send_range(8, 8);
    chk_cnt++; if (o_overflow !== 1'b0) $display("FAIL ovf_before_drop got %b want 0", o_overflow); else pass_cnt++;
    send(SW'(99), 1'b0);
    chk_cnt++; if (o_overflow !== 1'b1) $display("FAIL ovf_after_drop got %b want 1", o_overflow); else pass_cnt++;
`ifdef FFT_LOADER_DROP_CNT_EN
    chk_cnt++; if (o_drop_cnt !== 16'd1) $display("FAIL drop_cnt got %0d want 1", o_drop_cnt); else pass_cnt++;
`endif
    rd(3'd0);
    chk_cnt++; if (o_rd_data !== cword(24'd0)) $display("FAIL bank0_addr0 got %h want %h", o_rd_data, cword(24'd0)); else pass_cnt++;
    rd(3'd1);
    chk_cnt++; if (o_rd_data !== cword(24'd4)) $display("FAIL bank0_addr1 got %h want %h", o_rd_data, cword(24'd4)); else pass_cnt++;
    frame_done();
    chk_cnt++; if (o_frame_ready !== 1'b1) $display("FAIL bank1_ready got %b want 1", o_frame_ready); else pass_cnt++;
    rd(3'd0);
    chk_cnt++; if (o_rd_data !== cword(24'd8)) $display("FAIL bank1_addr0 got %h want %h", o_rd_data, cword(24'd8)); else pass_cnt++;
    rd(3'd1);
    chk_cnt++; if (o_rd_data !== cword(24'd12)) $display("FAIL bank1_addr1 got %h want %h", o_rd_data, cword(24'd12)); else pass_cnt++;
    chk_cnt++; if (o_overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", o_overflow); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    send_range(20, 5);
    do_reset();
    chk_cnt++; if (o_frame_ready !== 1'b0) $display("FAIL midrst_ready got %b want 0", o_frame_ready); else pass_cnt++;
    chk_cnt++; if (o_overflow !== 1'b0) $display("FAIL midrst_overflow got %b want 0", o_overflow); else pass_cnt++;
    chk_cnt++; if (o_rd_data !== '0) $display("FAIL midrst_rd_data got %h want 0", o_rd_data); else pass_cnt++;
    send_range(30, 7);
    chk_cnt++; if (o_frame_ready !== 1'b0) $display("FAIL midrst_ready_7 got %b want 0", o_frame_ready); else pass_cnt++;
    send(SW'(37), 1'b0);
    chk_cnt++; if (o_frame_ready !== 1'b1) $display("FAIL midrst_ready_8 got %b want 1", o_frame_ready); else pass_cnt++;
    rd(3'd1);
    chk_cnt++; if (o_rd_data !== cword(24'd34)) $display("FAIL midrst_addr1 got %h want %h", o_rd_data, cword(24'd34)); else pass_cnt++;
    rd(3'd5);
    chk_cnt++; if (o_rd_data !== cword(24'd35)) $display("FAIL midrst_addr5 got %h want %h", o_rd_data, cword(24'd35)); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_range(40, 8);
    // second frame: negative extremes first, then 50..55
    send(16'h8000, 1'b0);
    send(16'hFFFF, 1'b0);
    send_range(50, 5);
    send(SW'(55), 1'b1);   // completes bank 1 while releasing bank 0
    chk_cnt++; if (o_frame_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", o_frame_ready); else pass_cnt++;
    rd(3'd0);
    chk_cnt++; if (o_rd_data !== cword(24'hFF8000)) $display("FAIL sext_8000 got %h want %h", o_rd_data, cword(24'hFF8000)); else pass_cnt++;
    rd(3'd4);
    chk_cnt++; if (o_rd_data !== cword(24'hFFFFFF)) $display("FAIL sext_ffff got %h want %h", o_rd_data, cword(24'hFFFFFF)); else pass_cnt++;
    rd(3'd2);
    chk_cnt++; if (o_rd_data !== cword(24'd50)) $display("FAIL b2b_addr2 got %h want %h", o_rd_data, cword(24'd50)); else pass_cnt++;
    // bank 0 was freed, so a full frame goes in without a drop
    send_range(60, 8);
    chk_cnt++; if (o_overflow !== 1'b0) $display("FAIL b2b_no_drop got %b want 0", o_overflow); else pass_cnt++;
    frame_done();
    chk_cnt++; if (o_frame_ready !== 1'b1) $display("FAIL b2b_bank0_ready got %b want 1", o_frame_ready); else pass_cnt++;
    rd(3'd1);
    chk_cnt++; if (o_rd_data !== cword(24'd64)) $display("FAIL b2b_bank0_addr1 got %h want %h", o_rd_data, cword(24'd64)); else pass_cnt++;
    frame_done();
    chk_cnt++; if (o_frame_ready !== 1'b0) $display("FAIL b2b_drained got %b want 0", o_frame_ready); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_overflow();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24: width of each real/imag part of output complex words.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 24: input audio sample width, SAMPLE_WIDTH <= DATA_WIDTH.
REQ-003 SHALL have parameter FFT_POINTS, default 1024: frame length, power of 2, >= 4; ADDR_W = log2(FFT_POINTS).
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_sample_valid  input  1  one sample accepted per cycle when high.
REQ-007 SHALL have port i_sample  input  SAMPLE_WIDTH  signed real audio sample.
REQ-008 SHALL have port i_rd_en  input  1  read request from FFT controller.
REQ-009 SHALL have port i_rd_addr  input  ADDR_W  read address within the frame bank.
REQ-010 SHALL have port i_frame_done  input  1  single-cycle pulse: FFT has finished with the current frame.
REQ-011 SHALL have port o_rd_data  output  2*DATA_WIDTH  complex word {re, im}, re in upper half.
REQ-012 SHALL have port o_frame_ready  output  1  a full frame is available for reading.
REQ-013 SHALL have port o_overflow  output  1  sticky flag: a sample was dropped.

Function
REQ-014 SHALL hold two banks (0, 1) of FFT_POINTS complex words; state: wr_bank, rd_bank, wr_cnt (ADDR_W bits), full[1:0].
REQ-015 SHALL, on i_sample_valid with full[wr_bank]=0, write {sign-extend(i_sample) to DATA_WIDTH, DATA_WIDTH'b0} to bank wr_bank at address bitrev(wr_cnt), then increment wr_cnt.
REQ-016 SHALL, on the write with wr_cnt = FFT_POINTS-1, set full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0, all in the same cycle.
REQ-017 SHALL, on i_sample_valid with full[wr_bank]=1, drop the sample, leave wr_cnt, wr_bank and memory unchanged, and set o_overflow.
REQ-018 SHALL drive o_frame_ready = full[rd_bank] (registered state, no combinational path from inputs).
REQ-019 SHALL, on i_rd_en, present bank rd_bank word at i_rd_addr on o_rd_data exactly 1 cycle later; o_rd_data holds its value when i_rd_en=0.
REQ-020 SHALL, on i_frame_done with o_frame_ready=1, clear full[rd_bank] and toggle rd_bank; i_frame_done with o_frame_ready=0 SHALL be ignored.
REQ-021 SHALL handle simultaneous frame completion (REQ-016) and i_frame_done (REQ-020) in one cycle; they always target different banks and both take effect.
REQ-022 SHALL, when i_frame_done frees the bank the writer is blocked on, accept samples into it from the next cycle on.
REQ-023 SHALL not alter bank rd_bank contents while full[rd_bank]=1.
REQ-024 SHALL answer reads when o_frame_ready=0 with undefined data but no state change.

Reset
REQ-025 SHALL, on reset, set wr_bank=0, rd_bank=0, wr_cnt=0, full=2'b00, o_overflow=0, o_rd_data=0, o_frame_ready=0.
REQ-026 SHALL, on reset mid-frame, discard the partial frame and any full frames; memory contents are not cleared.
REQ-027 SHALL give reset priority over all other inputs in the same cycle.

Configuration
REQ-028 SHALL, with macro FFT_LOADER_DROP_CNT_EN defined, add output o_drop_cnt (16 bits), counting dropped samples, saturating at 16'hFFFF, reset to 0.
REQ-029 SHALL, without FFT_LOADER_DROP_CNT_EN, omit o_drop_cnt and its counter; all other behaviour identical.

Verification (FFT_POINTS=8, DATA_WIDTH=24, SAMPLE_WIDTH=16)
REQ-030 SHALL cover: samples 0..7 valid back-to-back -> o_frame_ready rises cycle after 8th sample; read addr 1 -> re=4, addr 6 -> re=3, im=0.
REQ-031 SHALL cover: sample 16'h8000 -> o_rd_data re = 24'hFF8000, im = 0.
REQ-032 SHALL cover: 16 samples, no i_frame_done, then a 17th -> o_overflow=1, o_drop_cnt=1 (macro on), both banks still hold frames 0..7 and 8..15.
REQ-033 SHALL cover: i_frame_done in same cycle as 8th sample of second frame -> full=2'b10 after edge, rd_bank=1, o_frame_ready stays 1.
REQ-034 SHALL cover: reset after 5 samples of a frame -> o_frame_ready=0, next 8 samples form a complete frame in bank 0.
REQ-035 SHALL cover: i_frame_done pulse with o_frame_ready=0 -> no change to rd_bank or full.
